// File: rtl/aes_add_round_key.sv
// AES-128 round-key addition: XORs each accepted state with the round key picked by
// an internal round counter, behind a one-deep registered valid/ready output stage.
module aes_add_round_key #(
    parameter int NR = 10,
    parameter int W  = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_wr_en,
    input  logic [3:0]   key_wr_idx,
    input  logic [W-1:0] key_wr_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic [W-1:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_state,
    output logic [3:0]   out_round,
    output logic         out_last,
    output logic         seq_err
);
    localparam logic [3:0] NR_IDX = 4'(NR);

    logic [W-1:0] key_q [NR:0];
    logic [3:0]   rnd;
    logic         active;
    logic         accept;
    logic [3:0]   key_sel;
    logic         bad_seq;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Any in_first beat, or any beat while idle, is treated as round 0.
    always_comb begin
        key_sel = '0;
        bad_seq = 1'b0;
        if (active && !in_first)
            key_sel = rnd;
        if (active)
            bad_seq = in_first;
        else
            bad_seq = !in_first;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i <= NR; i++)
                key_q[i] <= '0;
            rnd       <= '0;
            active    <= 1'b0;
            out_valid <= 1'b0;
            out_state <= '0;
            out_round <= '0;
            out_last  <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            // Nonblocking write means a same-cycle accept still sees the old key.
            if (key_wr_en && key_wr_idx <= NR_IDX)
                key_q[key_wr_idx] <= key_wr_data;
            seq_err <= 1'b0;
            if (accept) begin
                out_valid <= 1'b1;
                out_state <= in_state ^ key_q[key_sel];
                out_round <= key_sel;
                out_last  <= (key_sel == NR_IDX);
                seq_err   <= bad_seq;
                if (key_sel == NR_IDX) begin
                    rnd    <= '0;
                    active <= 1'b0;
                end else begin
                    rnd    <= key_sel + 4'd1;
                    active <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_aes_add_round_key.sv
// Directed bench for aes_add_round_key: whitening vector, full block, backpressure,
// sequencing errors, key collision / out-of-range writes and mid-block reset.
module tb_aes_add_round_key;
    localparam int NR = 10;
    localparam int W  = 128;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_wr_en;
    logic [3:0]   key_wr_idx;
    logic [W-1:0] key_wr_data;
    logic         in_valid;
    logic         in_ready;
    logic         in_first;
    logic [W-1:0] in_state;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;
    logic         seq_err;

    int n_chk  = 0;
    int n_pass = 0;
    logic [W-1:0] kexp [0:NR];

    localparam logic [W-1:0] P    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [W-1:0] NEWK = 128'hdeadbeefcafef00d0123456789abcdef;

    always #5 clk = ~clk;

    aes_add_round_key #(.NR(NR), .W(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state),
        .out_round(out_round), .out_last(out_last), .seq_err(seq_err)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_key(input int idx, input logic [W-1:0] data);
        key_wr_en   = 1'b1;
        key_wr_idx  = 4'(idx);
        key_wr_data = data;
        tick();
        key_wr_en = 1'b0;
        if (idx <= NR) kexp[idx] = data;
    endtask

    task automatic beat(input logic first, input logic [W-1:0] st, input int r,
                        input logic se, input string tag);
        in_valid = 1'b1;
        in_first = first;
        in_state = st;
        tick();
        in_valid = 1'b0;
        in_first = 1'b0;
        chk($sformatf("%s vld", tag),   W'(out_valid), W'(1'b1));
        chk($sformatf("%s rnd", tag),   W'(out_round), W'(r));
        chk($sformatf("%s state", tag), out_state, st ^ kexp[r]);
        chk($sformatf("%s last", tag),  W'(out_last), W'(r == NR));
        chk($sformatf("%s serr", tag),  W'(seq_err), W'(se));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i <= NR; i++) kexp[i] = '0;
    endtask

    initial begin
        rst_n = 1'b0; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
        in_valid = 1'b0; in_first = 1'b0; in_state = '0; out_ready = 1'b1;

        // Reset state
        do_reset();
        chk("rst out_valid", W'(out_valid), '0);
        chk("rst out_state", out_state, '0);
        chk("rst out_round", W'(out_round), '0);
        chk("rst out_last",  W'(out_last), '0);
        chk("rst seq_err",   W'(seq_err), '0);
        chk("rst in_ready",  W'(in_ready), W'(1'b1));

        // Whitening vector
        wr_key(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        beat(1'b1, 128'h3243f6a8885a308d313198a2e0370734, 0, 1'b0, "white");
        chk("white vector", out_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
        do_reset();

        // Full block, back to back
        for (int i = 0; i <= NR; i++) wr_key(i, {16{8'(i)}});
        for (int i = 0; i <= NR; i++) begin
            beat(i == 0, '0, i, 1'b0, $sformatf("full%0d", i));
            chk($sformatf("full%0d const", i), out_state, {16{8'(i)}});
        end

        // Backpressure during round 4
        for (int i = 0; i <= 4; i++) beat(i == 0, P, i, 1'b0, $sformatf("bp%0d", i));
        out_ready = 1'b0;
        in_valid = 1'b1; in_first = 1'b0; in_state = P;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("stall%0d in_ready", c), W'(in_ready), '0);
            chk($sformatf("stall%0d rnd", c), W'(out_round), W'(4));
            chk($sformatf("stall%0d state", c), out_state, P ^ {16{8'h04}});
        end
        out_ready = 1'b1;
        beat(1'b0, P, 5, 1'b0, "bp release");

        // Abort with in_first at round 6
        beat(1'b1, P, 0, 1'b0 | 1'b1, "abort");
        beat(1'b0, P, 1, 1'b0, "post abort");
        for (int i = 2; i <= NR; i++) beat(1'b0, P, i, 1'b0, $sformatf("fin%0d", i));

        // Idle beat without in_first
        beat(1'b0, P, 0, 1'b1, "idle nofirst");
        beat(1'b0, P, 1, 1'b0, "post idle");
        beat(1'b0, P, 2, 1'b0, "blk r2");

        // Key write colliding with round 3 accept
        key_wr_en = 1'b1; key_wr_idx = 4'd3; key_wr_data = NEWK;
        beat(1'b0, P, 3, 1'b0, "collide");
        key_wr_en = 1'b0;
        chk("collide old key", out_state, P ^ {16{8'h03}});
        kexp[3] = NEWK;
        for (int i = 4; i <= NR; i++) beat(1'b0, P, i, 1'b0, $sformatf("c%0d", i));

        // Out-of-range writes must not touch any entry
        wr_key(12, {W{1'b1}});
        wr_key(15, {W{1'b1}});
        for (int i = 0; i <= 7; i++) beat(i == 0, P, i, 1'b0, $sformatf("nb%0d", i));
        chk("new key r3 check", W'(1'b1), W'(kexp[3] == NEWK));

        // Reset mid-block at round 7 with out_valid high
        chk("pre-rst valid", W'(out_valid), W'(1'b1));
        rst_n = 1'b0;
        tick();
        chk("mrst out_valid", W'(out_valid), '0);
        chk("mrst out_state", out_state, '0);
        chk("mrst out_round", W'(out_round), '0);
        chk("mrst out_last",  W'(out_last), '0);
        chk("mrst seq_err",   W'(seq_err), '0);
        chk("mrst in_ready",  W'(in_ready), W'(1'b1));
        rst_n = 1'b1;
        for (int i = 0; i <= NR; i++) kexp[i] = '0;
        beat(1'b1, P, 0, 1'b0, "after rst");
        chk("after rst passthru", out_state, P);
        beat(1'b0, P, 1, 1'b0, "after rst r1");
        chk("after rst key1 zero", out_state, P);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
